// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. Owns the word-granular program counter, drives the
//   instruction memory address, and captures {pc, instr} pairs into a 2-entry
//   queue that feeds decode over a valid/ready handshake. A redirect flushes
//   the queue and reloads the PC.
//
// Ports
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fetch_en       in   fetch permitted this cycle
//   pc_out         out  [31:0] word address to instruction memory (PC register)
//   instr_in       in   [31:0] instruction for pc_out, same cycle
//   redirect_valid in   load redirect_pc and flush queue
//   redirect_pc    in   [31:0] redirect target word address
//   out_valid      out  queue head valid
//   out_ready      in   decode accepts head this cycle
//   out_instr      out  [31:0] instruction at queue head
//   out_pc         out  [31:0] PC of instruction at queue head
//   flushed        out  registered pulse, the cycle after a redirect
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        flushed
);

  // Queue occupancy limit; only a depth of 2 is supported by the entry logic.
  localparam logic [1:0] FULL_COUNT = DEPTH[1:0];

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] sec_instr_q, sec_instr_d;
  logic [31:0] sec_pc_q, sec_pc_d;
  logic        flushed_q, flushed_d;

  logic pop;
  logic push;

  assign out_valid = (count_q != 2'd0);
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;
  assign pc_out    = pc_q;
  assign flushed   = flushed_q;

  assign pop  = out_valid & out_ready;
  // A full queue can still accept a new entry when the head leaves this cycle.
  assign push = fetch_en & ~redirect_valid & ((count_q != FULL_COUNT) | pop);

  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    sec_instr_d  = sec_instr_q;
    sec_pc_d     = sec_pc_q;
    flushed_d    = 1'b0;

    if (redirect_valid) begin
      // Entry registers keep their contents; only the count clears, so the
      // out_* values hold while out_valid is low.
      pc_d      = redirect_pc;
      count_d   = 2'd0;
      flushed_d = 1'b1;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd1;
      end
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_instr_d = instr_in;
            head_pc_d    = pc_q;
          end else begin
            sec_instr_d  = instr_in;
            sec_pc_d     = pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_instr_d = sec_instr_q;
            head_pc_d    = sec_pc_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_instr_d = instr_in;
            head_pc_d    = pc_q;
          end else begin
            head_instr_d = sec_instr_q;
            head_pc_d    = sec_pc_q;
            sec_instr_d  = instr_in;
            sec_pc_d     = pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      head_instr_q <= 32'd0;
      head_pc_q    <= 32'd0;
      sec_instr_q  <= 32'd0;
      sec_pc_q     <= 32'd0;
      flushed_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      sec_instr_q  <= sec_instr_d;
      sec_pc_q     <= sec_pc_d;
      flushed_q    <= flushed_d;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the instruction memory. It owns the program counter, drives the memory's word address, and captures each returned instruction with its PC into a 2-entry queue. The queue feeds the decode stage through a valid/ready handshake. Control flow is changed by a redirect input that flushes the queue and reloads the PC.

## Interface
- RESET_PC, 32'h0, PC value loaded on reset.
- DEPTH, 2, queue entries (fixed at 2; other values unsupported).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  1 = fetch permitted this cycle.
- pc_out  out  32  word address to instruction memory; equals internal PC register.
- instr_in  in  32  instruction from memory; valid combinationally in the same cycle as pc_out.
- redirect_valid  in  1  1 = load new PC, flush queue.
- redirect_pc  in  32  target word address for redirect.
- out_valid  out  1  queue head holds a valid entry.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  instruction at queue head.
- out_pc  out  32  PC of the instruction at queue head.
- flushed  out  1  1-cycle pulse, registered, asserted the cycle after a redirect was taken.

## Operation
- Addressing is word-granular: sequential PC advances by 1, not 4. Arithmetic is 32-bit, wraps 32'hFFFF_FFFF -> 32'h0 silently.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < 2 | pop).
- On push: entry {pc_out, instr_in} is written to the tail and PC <= PC + 1.
- On pop: head entry is removed; the second entry, if any, becomes head in the next cycle.
- Push and pop in the same cycle: count unchanged, full throughput of 1 instruction/cycle.
- Redirect (highest priority): count <= 0, PC <= redirect_pc, flushed <= 1, no push. Any pop asserted that cycle still counts as consumed by decode, but the queue is cleared regardless.
- Full (count = 2) without pop: no push, PC holds, pc_out stable.
- fetch_en = 0: no push, PC holds. Queue still drains normally.
- Queue state is count in 0..2. The head and second entries are registers. out_* are driven from the head register, not from instr_in.
- When out_valid = 0, out_instr and out_pc hold their last values, and decode must ignore them.
- Reset values: PC = RESET_PC, pc_out = RESET_PC, count = 0, out_valid = 0, out_instr = 0, out_pc = 0, flushed = 0.
- Reset asserted mid-operation immediately clears the queue and reloads RESET_PC asynchronously. No entry survives.

## Timing
- Fetch latency: instruction at PC p is pushed on edge N and appears on out_* with out_valid = 1 after edge N (1 cycle from pc_out = p).
- First cycle after rst_n rises: pc_out = RESET_PC, out_valid = 0. After the first edge with fetch_en = 1: out_valid = 1 and out_pc = RESET_PC.
- Redirect on edge N: after edge N, out_valid = 0, pc_out = redirect_pc, flushed = 1. After edge N+1, out_pc = redirect_pc if fetch_en = 1 and redirect_valid = 0 at edge N+1.
- Back-to-back redirects: each one reloads PC. Only the last one takes effect for fetch.
- out_valid, out_instr and out_pc do not depend combinationally on out_ready. pc_out depends only on registered state.

## Test plan
- Reset: hold rst_n = 0, then release -> pc_out = 0, out_valid = 0, flushed = 0. Queue empty until the first enabled edge.
- Streaming: memory holds 0x0000, 0x1111, 0x2222, 0x3333 at addresses 0-3; fetch_en = 1, out_ready = 1 -> on consecutive cycles out_pc = 0, 1, 2, 3 and out_instr = 0x0000, 0x1111, 0x2222, 0x3333, with no bubbles.
- Backpressure: out_ready = 0 from reset -> after 2 edges count = 2, pc_out holds at 2, out_pc = 0. Then raise out_ready -> entries 0, 1, 2 delivered in order, nothing lost or duplicated.
- Redirect while full: queue holds PCs 0 and 1; pulse redirect_valid with redirect_pc = 0x40 -> next cycle out_valid = 0, flushed = 1, pc_out = 0x40. The cycle after, out_pc = 0x40.
- fetch_en gating: drop fetch_en with 1 entry queued and out_ready = 1 -> entry drains, out_valid = 0 and PC frozen. Re-enable -> fetch resumes at the frozen PC.
- Reset mid-stream: assert rst_n = 0 asynchronously between edges while out_valid = 1 -> out_valid = 0 and pc_out = RESET_PC without waiting for a clock edge.
